dtc_event_gather: RTL and testbench
===================================

Name: dtc_event_gather

Overview:
- Parametrised successor of the fixed 40-channel DTC trigger fan-out and RAM-flag aggregation logic.
- Fans masked FeeTrig/rdocmd/abortcmd out to NCH DTC channels and collects the per-channel event-RAM-ready flags.
- Adds a configurable completion timeout and a sequencer that hands ready channels one at a time to the DDL readout path, honouring xoff.
- Sits between the trigger/DDL control logic and the array of dtc_master_top instances.

Parameters:
- NCH, 40, number of DTC channels (1..64).
- TO_W, 16, width of the timeout counter and of timeout_cfg.
- CH_W, $clog2(NCH) (minimum 1), width of the channel index.

Ports:
- dcsclk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- dtc_mask  in  NCH  1 = channel excluded.
- FeeTrig  in  1  trigger pulse.
- rdocmd  in  1  readout command pulse.
- abortcmd  in  1  abort pulse.
- timeout_cfg  in  TO_W  cycles to wait for flags; 0 = wait forever.
- ddl_xoff  in  1  DDL back-pressure; stalls channel hand-off.
- DtcRamFlag_i  in  NCH  per-channel event RAM full/ready.
- rd_ch_done  in  1  readout of the current channel finished (pulse).
- FeeTrig_o  out  NCH  masked trigger, registered.
- rdocmd_o  out  NCH  masked readout command, registered.
- abortcmd_o  out  NCH  masked abort, registered.
- DTCEventRdy  out  NCH  DtcRamFlag_i | dtc_mask, registered.
- DtcRamFlag  out  1  all unmasked channels ready.
- rd_ch  out  CH_W  channel being read.
- rd_ch_valid  out  1  rd_ch valid; held until rd_ch_done.
- DtcRamReadConfirm  out  1  one-cycle pulse at end of event.
- timeout_err  out  1  sticky: last event timed out.
- missing_map  out  NCH  unmasked channels not ready at timeout.
- rdo_overrun  out  1  sticky: rdocmd received while busy.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- Fan-out: X_o[k] <= X & ~dtc_mask[k], 1-cycle latency, independent of the FSM.
- Flag aggregation:
  - DTCEventRdy <= DtcRamFlag_i | dtc_mask.
  - DtcRamFlag <= 1 when DTCEventRdy is all ones and dtc_mask is not all ones; otherwise 0.
  - Total latency is 2 cycles.
- FSM states: IDLE, WAIT_FLAGS, SCAN, SEND, CONFIRM.
- IDLE:
  - rdocmd with at least one unmasked channel → WAIT_FLAGS. Clears timeout_err and missing_map, and zeroes the timeout counter.
  - rdocmd with all channels masked is ignored.
- WAIT_FLAGS:
  - DtcRamFlag=1 → SCAN with scan index 0.
  - Otherwise the counter increments each cycle. On reaching timeout_cfg (when timeout_cfg != 0): set timeout_err, latch missing_map = ~DTCEventRdy, and go to SCAN. The counter saturates and does not wrap.
- SCAN:
  - Advances one index per cycle.
  - Skips channels that are masked or in missing_map.
  - On finding an eligible channel with ddl_xoff=0: set rd_ch, assert rd_ch_valid, go to SEND.
  - If an eligible channel is found while ddl_xoff=1, hold the index.
  - After index NCH-1 → CONFIRM.
- SEND:
  - rd_ch_valid and rd_ch are held stable until rd_ch_done.
  - rd_ch_done drops valid in the same clock edge; index+1 → SCAN, or CONFIRM if the index was NCH-1.
  - ddl_xoff does not affect a channel already in SEND.
- CONFIRM: DtcRamReadConfirm=1 for exactly one cycle, then → IDLE.
- abortcmd in any non-IDLE state:
  - → IDLE next cycle; rd_ch_valid drops; no confirm pulse.
  - Has priority over a simultaneous rdocmd, rd_ch_done or timeout.
- rdocmd in any non-IDLE state: ignored, and rdo_overrun is set. rdo_overrun clears only on reset.
- dtc_mask is treated as quasi-static. A change mid-event affects SCAN eligibility from the next cycle only.
- reset mid-operation: immediate return to reset values on the clock edge; no confirm pulse.

Decomposition:
- Shared package (sru_pkg):
  - FSM state enum.
  - NCH_DEFAULT = 40.
  - TO_W_DEFAULT = 16.
- One sub-module: dtc_rdo_scan. Holds the SCAN/SEND index logic: next eligible channel search, wrap detection, xoff hold.
- Fan-out and aggregation stay in the top level.

Test Plan:
- NCH=40, mask=0, pulse FeeTrig → FeeTrig_o=40'hFF_FFFF_FFFF one cycle later, width 1 cycle; with mask=40'h1 → bit0=0.
- mask=40'hFF_FFFF_FFF0, rdocmd, DtcRamFlag_i[3:0] raised at cycle 5 → DtcRamFlag at cycle 7.
  - rd_ch 0,1,2,3 presented in order, each released by rd_ch_done.
  - Then one DtcRamReadConfirm pulse; timeout_err=0.
- timeout_cfg=100, only channels 0 and 2 of 4 unmasked ready → at cycle 100 timeout_err=1, missing_map=4'b1010; only ch0 and ch2 read; confirm pulses.
- ddl_xoff=1 during SCAN → rd_ch_valid stays 0; xoff released → rd_ch_valid asserts within 1 cycle; xoff during SEND does not drop valid.
- abortcmd coincident with rd_ch_done on ch1 → busy=0 next cycle, no confirm, abortcmd_o pulses on unmasked channels.
- rdocmd while in WAIT_FLAGS → rdo_overrun=1 and the event proceeds unchanged; all-masked rdocmd → busy stays 0, DtcRamFlag=0.

Source files
------------

// File: rtl/sru_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sru_pkg : shared constants and FSM state type for DTC event gather   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sru_pkg;

  localparam int NCH_DEFAULT  = 40;
  localparam int TO_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_FLAGS = 3'd1,
    ST_SCAN       = 3'd2,
    ST_SEND       = 3'd3,
    ST_CONFIRM    = 3'd4
  } gather_state_e;

endpackage
`default_nettype wire

// File: rtl/dtc_rdo_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dtc_rdo_scan : channel index walker for the readout hand-off         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dtc_rdo_scan #(
  parameter int NCH  = 40,
  parameter int CH_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            scan_en,
  input  logic            send_en,
  input  logic            xoff,
  input  logic            ch_done,
  input  logic [NCH-1:0]  eligible,
  output logic [CH_W-1:0] idx,
  output logic            hit,
  output logic            wrap
);

  localparam logic [CH_W-1:0] LAST = CH_W'(NCH - 1);

  logic cur_elig;
  logic at_last;
  logic step;

  assign cur_elig = eligible[idx];
  assign at_last  = (idx == LAST);
  // An eligible channel blocked by xoff neither hits nor steps, so the index holds.
  assign hit      = scan_en & cur_elig & ~xoff;
  assign step     = (scan_en & ~cur_elig) | (send_en & ch_done);
  assign wrap     = step & at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (start) begin
      idx <= '0;
    end else if (step && !at_last) begin
      idx <= idx + CH_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/dtc_event_gather.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dtc_event_gather : DTC trigger fan-out, RAM-flag gather, readout seq |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dtc_event_gather
  import sru_pkg::*;
#(
  parameter int NCH  = NCH_DEFAULT,
  parameter int TO_W = TO_W_DEFAULT,
  parameter int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            dcsclk,
  input  logic            reset,
  input  logic [NCH-1:0]  dtc_mask,
  input  logic            FeeTrig,
  input  logic            rdocmd,
  input  logic            abortcmd,
  input  logic [TO_W-1:0] timeout_cfg,
  input  logic            ddl_xoff,
  input  logic [NCH-1:0]  DtcRamFlag_i,
  input  logic            rd_ch_done,
  output logic [NCH-1:0]  FeeTrig_o,
  output logic [NCH-1:0]  rdocmd_o,
  output logic [NCH-1:0]  abortcmd_o,
  output logic [NCH-1:0]  DTCEventRdy,
  output logic            DtcRamFlag,
  output logic [CH_W-1:0] rd_ch,
  output logic            rd_ch_valid,
  output logic            DtcRamReadConfirm,
  output logic            timeout_err,
  output logic [NCH-1:0]  missing_map,
  output logic            rdo_overrun,
  output logic            busy
);

  gather_state_e   state;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_cnt_nxt;
  logic            timeout_hit;
  logic            all_masked;
  logic [NCH-1:0]  eligible;
  logic            scan_start;
  logic [CH_W-1:0] scan_idx;
  logic            scan_hit;
  logic            scan_wrap;

  assign all_masked  = &dtc_mask;
  assign eligible    = ~dtc_mask & ~missing_map;
  assign to_cnt_nxt  = (&to_cnt) ? to_cnt : to_cnt + TO_W'(1);
  assign timeout_hit = (timeout_cfg != '0) && (to_cnt_nxt >= timeout_cfg);
  assign scan_start  = (state == ST_WAIT_FLAGS) && (DtcRamFlag || timeout_hit);

  assign DtcRamReadConfirm = (state == ST_CONFIRM);
  assign busy              = (state != ST_IDLE);

  always_ff @(posedge dcsclk) begin
    if (reset) begin
      FeeTrig_o   <= '0;
      rdocmd_o    <= '0;
      abortcmd_o  <= '0;
      DTCEventRdy <= '0;
      DtcRamFlag  <= 1'b0;
    end else begin
      FeeTrig_o   <= {NCH{FeeTrig}} & ~dtc_mask;
      rdocmd_o    <= {NCH{rdocmd}} & ~dtc_mask;
      abortcmd_o  <= {NCH{abortcmd}} & ~dtc_mask;
      DTCEventRdy <= DtcRamFlag_i | dtc_mask;
      DtcRamFlag  <= (&DTCEventRdy) & ~all_masked;
    end
  end

  always_ff @(posedge dcsclk) begin
    if (reset) begin
      state       <= ST_IDLE;
      to_cnt      <= '0;
      timeout_err <= 1'b0;
      missing_map <= '0;
      rdo_overrun <= 1'b0;
      rd_ch       <= '0;
      rd_ch_valid <= 1'b0;
    end else begin
      if (rdocmd && state != ST_IDLE) begin
        rdo_overrun <= 1'b1;
      end
      // Abort outranks every other event once an event is in flight.
      if (abortcmd && state != ST_IDLE) begin
        state       <= ST_IDLE;
        rd_ch_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rdocmd && !all_masked) begin
              state       <= ST_WAIT_FLAGS;
              timeout_err <= 1'b0;
              missing_map <= '0;
              to_cnt      <= '0;
            end
          end
          ST_WAIT_FLAGS: begin
            if (DtcRamFlag) begin
              state <= ST_SCAN;
            end else begin
              to_cnt <= to_cnt_nxt;
              if (timeout_hit) begin
                timeout_err <= 1'b1;
                missing_map <= ~DTCEventRdy;
                state       <= ST_SCAN;
              end
            end
          end
          ST_SCAN: begin
            if (scan_hit) begin
              rd_ch       <= scan_idx;
              rd_ch_valid <= 1'b1;
              state       <= ST_SEND;
            end else if (scan_wrap) begin
              state <= ST_CONFIRM;
            end
          end
          ST_SEND: begin
            if (rd_ch_done) begin
              rd_ch_valid <= 1'b0;
              state       <= scan_wrap ? ST_CONFIRM : ST_SCAN;
            end
          end
          ST_CONFIRM: state <= ST_IDLE;
          default:    state <= ST_IDLE;
        endcase
      end
    end
  end

  dtc_rdo_scan #(
    .NCH  (NCH),
    .CH_W (CH_W)
  ) u_scan (
    .clk      (dcsclk),
    .rst      (reset),
    .start    (scan_start),
    .scan_en  (state == ST_SCAN),
    .send_en  (state == ST_SEND),
    .xoff     (ddl_xoff),
    .ch_done  (rd_ch_done),
    .eligible (eligible),
    .idx      (scan_idx),
    .hit      (scan_hit),
    .wrap     (scan_wrap)
  );

endmodule
`default_nettype wire

// File: tb/tb_dtc_event_gather.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dtc_event_gather : scenario bench with readout-order scoreboard   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dtc_event_gather;

  localparam int NCH  = 40;
  localparam int TO_W = 16;
  localparam int CH_W = 6;

  localparam logic [NCH-1:0] LOW4  = 40'h00_0000_000F;
  localparam logic [NCH-1:0] MASK4 = 40'hFF_FFFF_FFF0;
  localparam logic [NCH-1:0] ALL1  = 40'hFF_FFFF_FFFF;

  logic            dcsclk = 1'b0;
  logic            reset;
  logic [NCH-1:0]  dtc_mask;
  logic            FeeTrig;
  logic            rdocmd;
  logic            abortcmd;
  logic [TO_W-1:0] timeout_cfg;
  logic            ddl_xoff;
  logic [NCH-1:0]  DtcRamFlag_i;
  logic            rd_ch_done;
  logic [NCH-1:0]  FeeTrig_o;
  logic [NCH-1:0]  rdocmd_o;
  logic [NCH-1:0]  abortcmd_o;
  logic [NCH-1:0]  DTCEventRdy;
  logic            DtcRamFlag;
  logic [CH_W-1:0] rd_ch;
  logic            rd_ch_valid;
  logic            DtcRamReadConfirm;
  logic            timeout_err;
  logic [NCH-1:0]  missing_map;
  logic            rdo_overrun;
  logic            busy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_q[$];

  always #5 dcsclk = ~dcsclk;

  dtc_event_gather #(.NCH(NCH), .TO_W(TO_W)) dut (
    .dcsclk            (dcsclk),
    .reset             (reset),
    .dtc_mask          (dtc_mask),
    .FeeTrig           (FeeTrig),
    .rdocmd            (rdocmd),
    .abortcmd          (abortcmd),
    .timeout_cfg       (timeout_cfg),
    .ddl_xoff          (ddl_xoff),
    .DtcRamFlag_i      (DtcRamFlag_i),
    .rd_ch_done        (rd_ch_done),
    .FeeTrig_o         (FeeTrig_o),
    .rdocmd_o          (rdocmd_o),
    .abortcmd_o        (abortcmd_o),
    .DTCEventRdy       (DTCEventRdy),
    .DtcRamFlag        (DtcRamFlag),
    .rd_ch             (rd_ch),
    .rd_ch_valid       (rd_ch_valid),
    .DtcRamReadConfirm (DtcRamReadConfirm),
    .timeout_err       (timeout_err),
    .missing_map       (missing_map),
    .rdo_overrun       (rdo_overrun),
    .busy              (busy)
  );

  task automatic tick();
    @(posedge dcsclk);
    #1;
  endtask

  task automatic settle();
    DtcRamFlag_i = '0;
    ddl_xoff     = 1'b0;
    repeat (3) tick();
  endtask

  // Consumes the scoreboard: each presented channel must match the next expected one.
  task automatic run_readout(input string tag, input int budget);
    bit got_conf = 1'b0;
    int n = 0;
    int e;
    logic [CH_W-1:0] ev;
    while (n < budget && !got_conf) begin
      if (DtcRamReadConfirm === 1'b1) begin
        got_conf = 1'b1;
      end else if (rd_ch_valid === 1'b1) begin
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL %s_extra_ch: got ch %0d, expected no further channel", tag, rd_ch);
        end else begin
          e  = exp_q.pop_front();
          ev = e[CH_W-1:0];
          if (rd_ch !== ev) $display("FAIL %s_rd_ch: got %0d expected %0d", tag, rd_ch, ev);
          else pass_cnt++;
        end
        rd_ch_done = 1'b1;
        tick();
        rd_ch_done = 1'b0;
        n++;
      end else begin
        tick();
        n++;
      end
    end
    total_cnt++;
    if (!got_conf || exp_q.size() != 0)
      $display("FAIL %s_confirm: confirm seen %0d, %0d channels unread, expected 1 and 0",
               tag, got_conf, exp_q.size());
    else pass_cnt++;
    if (got_conf) begin
      tick();
      total_cnt++;
      if (DtcRamReadConfirm !== 1'b0 || busy !== 1'b0)
        $display("FAIL %s_confirm_width: confirm %b busy %b expected 0 0", tag, DtcRamReadConfirm, busy);
      else pass_cnt++;
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; dtc_mask = '0; FeeTrig = 1'b1; rdocmd = 1'b0; abortcmd = 1'b0;
    timeout_cfg = '0; ddl_xoff = 1'b0; DtcRamFlag_i = ALL1; rd_ch_done = 1'b0;
    repeat (3) tick();
    total_cnt++;
    if (FeeTrig_o !== '0 || rdocmd_o !== '0 || abortcmd_o !== '0 || DTCEventRdy !== '0)
      $display("FAIL reset_vectors: trig %h rdo %h abort %h rdy %h expected all 0",
               FeeTrig_o, rdocmd_o, abortcmd_o, DTCEventRdy);
    else pass_cnt++;
    total_cnt++;
    if ({DtcRamFlag, rd_ch_valid, DtcRamReadConfirm, timeout_err, rdo_overrun, busy} !== 6'b0)
      $display("FAIL reset_flags: flag %b valid %b conf %b terr %b ovr %b busy %b expected 0",
               DtcRamFlag, rd_ch_valid, DtcRamReadConfirm, timeout_err, rdo_overrun, busy);
    else pass_cnt++;
    total_cnt++;
    if (missing_map !== '0 || rd_ch !== '0)
      $display("FAIL reset_map: missing %h rd_ch %0d expected 0 0", missing_map, rd_ch);
    else pass_cnt++;
    reset = 1'b0; FeeTrig = 1'b0;
    settle();
  endtask

  task automatic test_fanout();
    dtc_mask = '0;
    FeeTrig = 1'b1; tick(); FeeTrig = 1'b0;
    total_cnt++;
    if (FeeTrig_o !== ALL1) $display("FAIL fanout_all: got %h expected %h", FeeTrig_o, ALL1);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (FeeTrig_o !== '0) $display("FAIL fanout_width: got %h expected 0", FeeTrig_o);
    else pass_cnt++;
    dtc_mask = 40'h1;
    FeeTrig = 1'b1; tick(); FeeTrig = 1'b0;
    total_cnt++;
    if (FeeTrig_o !== 40'hFF_FFFF_FFFE) $display("FAIL fanout_mask: got %h expected FFFFFFFFFE", FeeTrig_o);
    else pass_cnt++;
    abortcmd = 1'b1; tick(); abortcmd = 1'b0;
    total_cnt++;
    if (abortcmd_o !== 40'hFF_FFFF_FFFE || busy !== 1'b0)
      $display("FAIL fanout_abort_idle: abort_o %h busy %b expected FFFFFFFFFE 0", abortcmd_o, busy);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_normal_event();
    dtc_mask = MASK4; timeout_cfg = '0;
    repeat (2) tick();
    rdocmd = 1'b1; tick(); rdocmd = 1'b0;
    total_cnt++;
    if (busy !== 1'b1 || rdocmd_o !== LOW4)
      $display("FAIL normal_start: busy %b rdocmd_o %h expected 1 %h", busy, rdocmd_o, LOW4);
    else pass_cnt++;
    repeat (3) tick();
    total_cnt++;
    if (rd_ch_valid !== 1'b0 || DtcRamFlag !== 1'b0)
      $display("FAIL normal_wait: valid %b flag %b expected 0 0", rd_ch_valid, DtcRamFlag);
    else pass_cnt++;
    DtcRamFlag_i = LOW4;
    tick();
    total_cnt++;
    if (DTCEventRdy !== ALL1 || DtcRamFlag !== 1'b0)
      $display("FAIL normal_lat1: rdy %h flag %b expected %h 0", DTCEventRdy, DtcRamFlag, ALL1);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (DtcRamFlag !== 1'b1) $display("FAIL normal_lat2: flag %b expected 1", DtcRamFlag);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    run_readout("normal", 200);
    total_cnt++;
    if (timeout_err !== 1'b0) $display("FAIL normal_terr: got %b expected 0", timeout_err);
    else pass_cnt++;
    settle();
  endtask

  task automatic test_timeout();
    int n = 0;
    dtc_mask = MASK4; timeout_cfg = 16'd100; DtcRamFlag_i = 40'h5;
    repeat (3) tick();
    exp_q.push_back(0);
    exp_q.push_back(2);
    rdocmd = 1'b1; tick(); rdocmd = 1'b0;
    while (timeout_err !== 1'b1 && n < 150) begin
      tick();
      n++;
    end
    total_cnt++;
    if (n != 100) $display("FAIL timeout_cycle: timeout after %0d cycles expected 100", n);
    else pass_cnt++;
    total_cnt++;
    if (missing_map !== 40'hA) $display("FAIL timeout_map: got %h expected a", missing_map);
    else pass_cnt++;
    run_readout("timeout", 200);
    total_cnt++;
    if (timeout_err !== 1'b1) $display("FAIL timeout_sticky: got %b expected 1", timeout_err);
    else pass_cnt++;
    timeout_cfg = '0;
    settle();
  endtask

  task automatic test_overrun();
    dtc_mask = MASK4;
    rdocmd = 1'b1; tick(); rdocmd = 1'b0;
    total_cnt++;
    if (timeout_err !== 1'b0 || missing_map !== '0)
      $display("FAIL overrun_clear: terr %b missing %h expected 0 0", timeout_err, missing_map);
    else pass_cnt++;
    rdocmd = 1'b1; tick(); rdocmd = 1'b0;
    total_cnt++;
    if (rdo_overrun !== 1'b1 || busy !== 1'b1)
      $display("FAIL overrun_set: ovr %b busy %b expected 1 1", rdo_overrun, busy);
    else pass_cnt++;
    DtcRamFlag_i = LOW4;
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    run_readout("overrun", 200);
    total_cnt++;
    if (rdo_overrun !== 1'b1) $display("FAIL overrun_sticky: got %b expected 1", rdo_overrun);
    else pass_cnt++;
    settle();
  endtask

  task automatic test_xoff();
    int e;
    dtc_mask = MASK4; DtcRamFlag_i = LOW4;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    ddl_xoff = 1'b1;
    rdocmd = 1'b1; tick(); rdocmd = 1'b0;
    repeat (6) tick();
    total_cnt++;
    if (busy !== 1'b1 || rd_ch_valid !== 1'b0)
      $display("FAIL xoff_hold: busy %b valid %b expected 1 0", busy, rd_ch_valid);
    else pass_cnt++;
    ddl_xoff = 1'b0; tick();
    e = exp_q.pop_front();
    total_cnt++;
    if (rd_ch_valid !== 1'b1 || rd_ch !== e[CH_W-1:0])
      $display("FAIL xoff_release: valid %b ch %0d expected 1 %0d", rd_ch_valid, rd_ch, e);
    else pass_cnt++;
    ddl_xoff = 1'b1;
    repeat (3) tick();
    total_cnt++;
    if (rd_ch_valid !== 1'b1 || rd_ch !== e[CH_W-1:0])
      $display("FAIL xoff_send: valid %b ch %0d expected 1 %0d", rd_ch_valid, rd_ch, e);
    else pass_cnt++;
    rd_ch_done = 1'b1; tick(); rd_ch_done = 1'b0;
    repeat (3) tick();
    total_cnt++;
    if (rd_ch_valid !== 1'b0) $display("FAIL xoff_next_hold: valid %b expected 0", rd_ch_valid);
    else pass_cnt++;
    ddl_xoff = 1'b0;
    run_readout("xoff", 200);
    settle();
  endtask

  task automatic test_abort();
    int n;
    int e;
    bit conf_seen = 1'b0;
    dtc_mask = MASK4; DtcRamFlag_i = LOW4;
    repeat (3) tick();
    exp_q.push_back(0);
    exp_q.push_back(1);
    rdocmd = 1'b1; tick(); rdocmd = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (rd_ch_valid !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      e = exp_q.pop_front();
      total_cnt++;
      if (rd_ch_valid !== 1'b1 || rd_ch !== e[CH_W-1:0])
        $display("FAIL abort_ch%0d: valid %b ch %0d expected 1 %0d", k, rd_ch_valid, rd_ch, e);
      else pass_cnt++;
      if (k == 0) begin
        rd_ch_done = 1'b1; tick(); rd_ch_done = 1'b0;
      end
    end
    rd_ch_done = 1'b1; abortcmd = 1'b1;
    tick();
    rd_ch_done = 1'b0; abortcmd = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || rd_ch_valid !== 1'b0 || abortcmd_o !== LOW4)
      $display("FAIL abort_now: busy %b valid %b abort_o %h expected 0 0 %h",
               busy, rd_ch_valid, abortcmd_o, LOW4);
    else pass_cnt++;
    for (int i = 0; i < 60; i++) begin
      conf_seen |= (DtcRamReadConfirm === 1'b1);
      tick();
    end
    total_cnt++;
    if (conf_seen || busy !== 1'b0 || abortcmd_o !== '0)
      $display("FAIL abort_noconf: confirm %b busy %b abort_o %h expected 0 0 0",
               conf_seen, busy, abortcmd_o);
    else pass_cnt++;
    settle();
  endtask

  task automatic test_all_masked();
    dtc_mask = ALL1;
    rdocmd = 1'b1; tick(); rdocmd = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || rdocmd_o !== '0)
      $display("FAIL allmask_ignore: busy %b rdocmd_o %h expected 0 0", busy, rdocmd_o);
    else pass_cnt++;
    repeat (2) tick();
    total_cnt++;
    if (DtcRamFlag !== 1'b0 || DTCEventRdy !== ALL1)
      $display("FAIL allmask_flag: flag %b rdy %h expected 0 %h", DtcRamFlag, DTCEventRdy, ALL1);
    else pass_cnt++;
    settle();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit conf_seen = 1'b0;
    dtc_mask = MASK4; DtcRamFlag_i = LOW4;
    repeat (3) tick();
    rdocmd = 1'b1; tick(); rdocmd = 1'b0;
    while (rd_ch_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    reset = 1'b1; tick(); reset = 1'b0;
    total_cnt++;
    if (rd_ch_valid !== 1'b0 || busy !== 1'b0 || rdo_overrun !== 1'b0 || DtcRamFlag !== 1'b0)
      $display("FAIL midreset: valid %b busy %b ovr %b flag %b expected 0 0 0 0",
               rd_ch_valid, busy, rdo_overrun, DtcRamFlag);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      conf_seen |= (DtcRamReadConfirm === 1'b1);
      tick();
    end
    total_cnt++;
    if (conf_seen || busy !== 1'b0)
      $display("FAIL midreset_noconf: confirm %b busy %b expected 0 0", conf_seen, busy);
    else pass_cnt++;
    settle();
  endtask

  initial begin
    test_reset();
    test_fanout();
    test_normal_event();
    test_timeout();
    test_overrun();
    test_xoff();
    test_abort();
    test_all_masked();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d of %0d passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
